// File: rtl/regfile_scoreboard_if.sv
// regfile_scoreboard_if: write, lock and dual read port bundle for the scoreboarded register file
interface regfile_scoreboard_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3
);
    logic              RegWrite;
    logic [ADDR_W-1:0] WriteReg;
    logic [DATA_W-1:0] WriteData;
    logic              LockEn;
    logic [ADDR_W-1:0] LockReg;
    logic [ADDR_W-1:0] ReadReg1;
    logic [ADDR_W-1:0] ReadReg2;
    logic [DATA_W-1:0] ReadData1;
    logic [DATA_W-1:0] ReadData2;
    logic              Busy1;
    logic              Busy2;
    modport master (
        output RegWrite, WriteReg, WriteData, LockEn, LockReg, ReadReg1, ReadReg2,
        input  ReadData1, ReadData2, Busy1, Busy2
    );
    modport slave (
        input  RegWrite, WriteReg, WriteData, LockEn, LockReg, ReadReg1, ReadReg2,
        output ReadData1, ReadData2, Busy1, Busy2
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: register file with per-register pending bits for multicycle producers
// and optional same-cycle write-to-read forwarding.
module regfile_scoreboard #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3,
    parameter int BYPASS = 1
) (
    input logic clk,
    input logic rst,
    regfile_scoreboard_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  pending;
    logic              wr_ok;
    logic              fwd1;
    logic              fwd2;
    logic              zero1;
    logic              zero2;
    assign wr_ok = bus.RegWrite && bus.WriteReg != '0;
    // the lock is applied after the write so a same-cycle lock wins the pending bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
            pending <= '0;
        end else begin
            if (wr_ok) begin
                regs[bus.WriteReg]    <= bus.WriteData;
                pending[bus.WriteReg] <= 1'b0;
            end
            if (bus.LockEn && bus.LockReg != '0) pending[bus.LockReg] <= 1'b1;
        end
    end
    assign fwd1  = BYPASS != 0 && wr_ok && bus.WriteReg == bus.ReadReg1;
    assign fwd2  = BYPASS != 0 && wr_ok && bus.WriteReg == bus.ReadReg2;
    assign zero1 = rst || bus.ReadReg1 == '0;
    assign zero2 = rst || bus.ReadReg2 == '0;
    always_comb begin
        bus.ReadData1 = zero1 ? '0 : fwd1 ? bus.WriteData : regs[bus.ReadReg1];
        bus.ReadData2 = zero2 ? '0 : fwd2 ? bus.WriteData : regs[bus.ReadReg2];
        bus.Busy1     = !zero1 && !fwd1 && pending[bus.ReadReg1];
        bus.Busy2     = !zero2 && !fwd2 && pending[bus.ReadReg2];
    end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed vectors into an expectation queue, drained by a monitor
// that compares both read ports of the forwarding and non-forwarding instances.
module tb_regfile_scoreboard;
    typedef struct {
        string       name;
        bit          dut;
        logic [31:0] d1;
        logic        b1;
        logic [31:0] d2;
        logic        b2;
    } exp_t;

    logic clk = 1'b0;
    logic clk_en = 1'b1;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    exp_t q[$];
    event smp;

    regfile_scoreboard_if #(.DATA_W(32), .ADDR_W(3)) a ();
    regfile_scoreboard_if #(.DATA_W(32), .ADDR_W(3)) b ();

    regfile_scoreboard #(.DATA_W(32), .ADDR_W(3), .BYPASS(1)) dut_a (.clk(clk), .rst(rst), .bus(a.slave));
    regfile_scoreboard #(.DATA_W(32), .ADDR_W(3), .BYPASS(0)) dut_b (.clk(clk), .rst(rst), .bus(b.slave));

    // gated clock so the mid-operation reset can be exercised with no edge at all
    initial forever #50 clk = clk_en ? ~clk : 1'b0;

    task automatic drive(input bit dut, input logic rw, input logic [2:0] wr, input logic [31:0] wd,
                         input logic le, input logic [2:0] lr, input logic [2:0] r1, input logic [2:0] r2);
        if (dut) begin
            b.RegWrite = rw; b.WriteReg = wr; b.WriteData = wd;
            b.LockEn = le; b.LockReg = lr; b.ReadReg1 = r1; b.ReadReg2 = r2;
        end else begin
            a.RegWrite = rw; a.WriteReg = wr; a.WriteData = wd;
            a.LockEn = le; a.LockReg = lr; a.ReadReg1 = r1; a.ReadReg2 = r2;
        end
    endtask

    task automatic chk(input bit dut, input string name, input logic [31:0] d1, input logic b1,
                       input logic [31:0] d2, input logic b2);
        exp_t e;
        #1;
        e.name = name; e.dut = dut; e.d1 = d1; e.b1 = b1; e.d2 = d2; e.b2 = b2;
        q.push_back(e);
        -> smp;
        #1;
    endtask

    initial forever begin
        exp_t        e;
        logic [31:0] d1, d2;
        logic        b1, b2;
        @(smp);
        if (q.size() == 0) begin
            fails++;
            $display("FAIL monitor: sample with empty queue, got 0 entries, need 1");
        end else begin
            e  = q.pop_front();
            d1 = e.dut ? b.ReadData1 : a.ReadData1;
            b1 = e.dut ? b.Busy1 : a.Busy1;
            d2 = e.dut ? b.ReadData2 : a.ReadData2;
            b2 = e.dut ? b.Busy2 : a.Busy2;
            tests++;
            if (d1 !== e.d1 || b1 !== e.b1 || d2 !== e.d2 || b2 !== e.b2) begin
                fails++;
                $display("FAIL %s (dut %0d): got d1=%h b1=%b d2=%h b2=%b, need d1=%h b1=%b d2=%h b2=%b",
                         e.name, e.dut, d1, b1, d2, b2, e.d1, e.b1, e.d2, e.b2);
            end
        end
    end

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        #10;
        // writes and locks presented during reset must not land
        drive(0, 1, 3, 32'h0000CAFE, 1, 4, 3, 4);
        chk(0, "rst_out", 0, 0, 0, 0);
        @(posedge clk);
        #10;
        chk(0, "rst_edge", 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 3, 4);
        chk(0, "rst_ignored", 0, 0, 0, 0);
        @(negedge clk);
        drive(0, 1, 3, 32'hDEADBEEF, 0, 0, 3, 0);
        chk(0, "fwd_same", 32'hDEADBEEF, 0, 0, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 3, 3);
        chk(0, "wr_rd", 32'hDEADBEEF, 0, 32'hDEADBEEF, 0);
        @(negedge clk);
        drive(0, 1, 0, 32'h12345678, 1, 0, 0, 0);
        chk(0, "r0_same", 0, 0, 0, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk(0, "r0_next", 0, 0, 0, 0);
        @(negedge clk);
        drive(0, 1, 5, 32'h11, 0, 0, 5, 3);
        chk(0, "r5_fwd", 32'h11, 0, 32'hDEADBEEF, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 1, 5, 5, 3);
        chk(0, "lock_same", 32'h11, 0, 32'hDEADBEEF, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 1, 5, 5, 5);
        chk(0, "locked", 32'h11, 1, 32'h11, 1);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 5, 5);
        chk(0, "relock", 32'h11, 1, 32'h11, 1);
        @(negedge clk);
        drive(0, 1, 5, 32'hA5, 0, 0, 5, 5);
        chk(0, "release_fwd", 32'hA5, 0, 32'hA5, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 5, 3);
        chk(0, "released", 32'hA5, 0, 32'hDEADBEEF, 0);
        @(negedge clk);
        drive(0, 1, 2, 32'h77, 1, 2, 2, 5);
        chk(0, "lockwr_same", 32'h77, 0, 32'hA5, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 2, 2);
        chk(0, "lock_wins", 32'h77, 1, 32'h77, 1);
        @(negedge clk);
        drive(0, 1, 1, 32'h99, 1, 7, 1, 7);
        chk(0, "indep_same", 32'h99, 0, 0, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 1, 7);
        chk(0, "indep", 32'h99, 0, 0, 1);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 1, 4, 32'h55, 0, 0, 4, 4);
        chk(1, "nobyp_same", 0, 0, 0, 0);
        @(negedge clk);
        drive(1, 0, 0, 0, 1, 4, 4, 0);
        chk(1, "nobyp_next", 32'h55, 0, 0, 0);
        @(negedge clk);
        drive(1, 1, 4, 32'h66, 0, 0, 4, 4);
        chk(1, "nobyp_busy", 32'h55, 1, 32'h55, 1);
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 0, 4, 4);
        chk(1, "nobyp_release", 32'h66, 0, 32'h66, 0);
        for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            drive(0, 1, 3'(i), 32'hFF, i == 7, 6, 0, 0);
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 6, 7);
        chk(0, "prefill", 32'hFF, 1, 32'hFF, 0);
        // in-flight write and lock are pending when reset hits between edges
        drive(0, 1, 7, 32'hAB, 1, 3, 6, 7);
        clk_en = 1'b0;
        #5;
        rst = 1'b1;
        for (int i = 1; i < 8; i++) begin
            drive(0, 1, 7, 32'hAB, 1, 3, 3'(i), 3'(8 - i));
            chk(0, "mid_rst", 0, 0, 0, 0);
        end
        rst = 1'b0;
        for (int i = 1; i < 8; i++) begin
            drive(0, 0, 0, 0, 0, 0, 3'(i), 3'(8 - i));
            chk(0, "post_rst", 0, 0, 0, 0);
        end
        clk_en = 1'b1;
        @(negedge clk);
        drive(0, 1, 3, 32'h12, 0, 0, 3, 6);
        chk(0, "fresh_fwd", 32'h12, 0, 0, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 3, 7);
        chk(0, "fresh", 32'h12, 0, 0, 0);
        @(negedge clk);
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d unchecked entries, need 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
